// File: rtl/apb_byte_serial_slave.sv
// APB3 slave over a byte-wide storage array; each transfer is serialised one byte lane per cycle.
// Optional build macro APB_SLV_WAIT_CNT_EN adds a saturating wait-state counter output wait_cnt.
module apb_byte_serial_slave #(
    parameter int DATA_BYTES  = 4,
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 32
) (
    input  logic                    p_clk,
    input  logic                    p_resetn,
    input  logic [ADDR_W-1:0]       p_addr,
    input  logic                    p_sel,
    input  logic                    p_enable,
    input  logic                    p_write,
    input  logic [8*DATA_BYTES-1:0] p_wdata,
    input  logic [DATA_BYTES-1:0]   p_strb,
    output logic [8*DATA_BYTES-1:0] p_rdata,
    output logic                    p_ready,
    output logic                    p_slverr
`ifdef APB_SLV_WAIT_CNT_EN
    ,
    output logic [31:0]             wait_cnt
`endif
);

    localparam int IDX_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int LANE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int AW1    = ADDR_W + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [DATA_BYTES-1:0]   pending_q, pending_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        base_q, base_d;
    logic [8*DATA_BYTES-1:0] rdata_q, rdata_d;
    logic [7:0]              mem_q [DEPTH_BYTES];

    logic              setup;
    logic              access;
    logic              last_lane;
    logic              addr_err;
    logic              lane_live;
    logic              wr_en;
    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  mem_idx;
    logic [7:0]        mem_byte;
    logic [7:0]        wr_byte;

    assign setup     = p_sel & ~p_enable;
    assign access    = (state_q == ST_XFER) & p_sel & p_enable;
    assign last_lane = (pending_q & (pending_q - DATA_BYTES'(1))) == '0;
    assign lane_live = access & ~err_q & (pending_q != '0);

    // Sum is one bit wider than the address so the top of the address space flags an error
    assign addr_err = ((p_addr % ADDR_W'(DATA_BYTES)) != '0)
                    | (({1'b0, p_addr} + AW1'(DATA_BYTES)) > AW1'(DEPTH_BYTES));

    always_comb begin
        lane = '0;
        for (int i = DATA_BYTES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lane = LANE_W'(i);
            end
        end
    end

    assign mem_idx  = base_q + IDX_W'(lane);
    assign mem_byte = mem_q[mem_idx];
    assign wr_byte  = p_wdata[8*int'(lane) +: 8];
    assign wr_en    = lane_live & p_write;

    assign p_ready  = access & (err_q | last_lane);
    assign p_slverr = access & err_q;

    // The lane being read this cycle is forwarded straight from storage
    always_comb begin
        p_rdata = rdata_q;
        if (lane_live & ~p_write) begin
            p_rdata[8*int'(lane) +: 8] = mem_byte;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        err_d     = err_q;
        base_d    = base_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    state_d   = ST_XFER;
                    pending_d = p_write ? p_strb : '1;
                    err_d     = addr_err;
                    base_d    = p_addr[IDX_W-1:0];
                    rdata_d   = '0;
                end
            end
            ST_XFER: begin
                if (!p_sel) begin
                    state_d   = ST_IDLE;
                    pending_d = '0;
                end else if (p_enable) begin
                    if (lane_live) begin
                        pending_d[lane] = 1'b0;
                        if (!p_write) begin
                            rdata_d[8*int'(lane) +: 8] = mem_byte;
                        end
                    end
                    if (p_ready) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            err_q     <= 1'b0;
            base_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            base_q    <= base_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[mem_idx] <= wr_byte;
        end
    end

`ifdef APB_SLV_WAIT_CNT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (p_sel && p_enable && !p_ready && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_apb_byte_serial_slave.sv
// Self-checking bench for apb_byte_serial_slave (DATA_BYTES=4, DEPTH_BYTES=64) against a byte-array model.
module tb_apb_byte_serial_slave;

    localparam int DB    = 4;
    localparam int DEPTH = 64;

    logic        p_clk    = 1'b0;
    logic        p_resetn = 1'b1;
    logic [31:0] p_addr   = '0;
    logic        p_sel    = 1'b0;
    logic        p_enable = 1'b0;
    logic        p_write  = 1'b0;
    logic [31:0] p_wdata  = '0;
    logic [3:0]  p_strb   = '0;
    logic [31:0] p_rdata;
    logic        p_ready;
    logic        p_slverr;
`ifdef APB_SLV_WAIT_CNT_EN
    logic [31:0] wait_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] model_mem [DEPTH];

    apb_byte_serial_slave #(
        .DATA_BYTES (DB),
        .DEPTH_BYTES(DEPTH),
        .ADDR_W     (32)
    ) dut (
        .p_clk   (p_clk),
        .p_resetn(p_resetn),
        .p_addr  (p_addr),
        .p_sel   (p_sel),
        .p_enable(p_enable),
        .p_write (p_write),
        .p_wdata (p_wdata),
        .p_strb  (p_strb),
        .p_rdata (p_rdata),
        .p_ready (p_ready),
        .p_slverr(p_slverr)
`ifdef APB_SLV_WAIT_CNT_EN
        ,
        .wait_cnt(wait_cnt)
`endif
    );

    always #5 p_clk = ~p_clk;

    // ---------------- reference model ----------------
    function automatic logic bad_addr(input logic [31:0] a);
        longint unsigned end_addr;
        end_addr = longint'(a) + longint'(DB);
        return ((a % 32'd4) != 32'd0) || (end_addr > longint'(DEPTH));
    endfunction

    function automatic int popc(input logic [3:0] s);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(s[i]);
        return n;
    endfunction

    function automatic int exp_cycles(input logic wr, input logic [31:0] a, input logic [3:0] s);
        if (bad_addr(a)) return 1;
        if (!wr) return DB;
        return (popc(s) > 1) ? popc(s) : 1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] v = '0;
        if (!bad_addr(a)) begin
            for (int i = 0; i < DB; i++) v[8*i +: 8] = model_mem[a + i];
        end
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!bad_addr(a)) begin
            for (int i = 0; i < DB; i++) if (s[i]) model_mem[a + i] = d[8*i +: 8];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    endtask

    // ---------------- bus driver (starts and ends at posedge+1) ----------------
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rdata,
                           output int cycles, output logic slverr);
        logic done = 1'b0;
        p_sel = 1'b1; p_enable = 1'b0; p_write = wr;
        p_addr = addr; p_wdata = wdata; p_strb = strb;
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        cycles = 0; rdata = '0; slverr = 1'b0;
        while (!done && cycles < 16) begin
            @(negedge p_clk);
            cycles++;
            if (p_ready) begin
                rdata  = p_rdata;
                slverr = p_slverr;
                done   = 1'b1;
            end
            @(posedge p_clk); #1;
        end
        p_sel = 1'b0; p_enable = 1'b0;
        if (!done) cycles = 99;
        $display("%s addr=0x%08h strb=%b wdata=0x%08h -> cycles=%0d slverr=%b rdata=0x%08h",
                 wr ? "WR" : "RD", addr, strb, wdata, cycles, slverr, rdata);
    endtask

    task automatic apply_reset();
        p_sel = 1'b0; p_enable = 1'b0;
        p_resetn = 1'b0;
        repeat (2) @(posedge p_clk);
        #1 p_resetn = 1'b1;
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd; int cyc; logic se;
        apply_reset();
        @(negedge p_clk);
        checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", p_ready); end
        checks++; if (p_slverr !== 1'b0) begin errors++; $display("FAIL reset_slverr: got %b expected 0", p_slverr); end
`ifdef APB_SLV_WAIT_CNT_EN
        checks++; if (wait_cnt !== 32'd0) begin errors++; $display("FAIL reset_wait_cnt: got %0d expected 0", wait_cnt); end
`endif
        @(posedge p_clk); #1;
        for (int w = 0; w < DEPTH / DB; w++) begin
            do_xfer(1'b0, 32'(w * DB), '0, '0, rd, cyc, se);
            checks++; if (rd !== 32'h0 || cyc != DB || se !== 1'b0) begin
                errors++; $display("FAIL reset_mem_word%0d: got data=0x%08h cycles=%0d slverr=%b expected data=0 cycles=4 slverr=0", w, rd, cyc, se);
            end
        end
    endtask

`ifdef APB_SLV_WAIT_CNT_EN
    task automatic test_wait_cnt();
        logic [31:0] rd; int cyc; logic se;
        apply_reset();
        do_xfer(1'b1, 32'h08, 32'hA1B2C3D4, 4'b1111, rd, cyc, se); model_write(32'h08, 32'hA1B2C3D4, 4'b1111);
        do_xfer(1'b0, 32'h08, '0, '0, rd, cyc, se);
        do_xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, cyc, se); model_write(32'h10, 32'h11223344, 4'b0101);
        do_xfer(1'b0, 32'h10, '0, '0, rd, cyc, se);
        @(negedge p_clk);
        checks++; if (wait_cnt !== 32'd10) begin errors++; $display("FAIL wait_cnt_total: got %0d expected 10", wait_cnt); end
        @(posedge p_clk); #1;
    endtask
`endif

    task automatic test_full_write_read();
        logic [31:0] rd; int cyc; logic se;
        do_xfer(1'b1, 32'h08, 32'hA1B2C3D4, 4'b1111, rd, cyc, se);
        model_write(32'h08, 32'hA1B2C3D4, 4'b1111);
        checks++; if (cyc != 4 || se !== 1'b0) begin errors++; $display("FAIL full_write: got cycles=%0d slverr=%b expected cycles=4 slverr=0", cyc, se); end
        do_xfer(1'b0, 32'h08, '0, '0, rd, cyc, se);
        checks++; if (rd !== 32'hA1B2C3D4) begin errors++; $display("FAIL full_read_data: got 0x%08h expected 0xa1b2c3d4", rd); end
        checks++; if (cyc != 4 || se !== 1'b0) begin errors++; $display("FAIL full_read_timing: got cycles=%0d slverr=%b expected cycles=4 slverr=0", cyc, se); end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] rd; int cyc; logic se;
        do_xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, cyc, se);
        model_write(32'h10, 32'h11223344, 4'b0101);
        checks++; if (cyc != 2 || se !== 1'b0) begin errors++; $display("FAIL strobe_write: got cycles=%0d slverr=%b expected cycles=2 slverr=0", cyc, se); end
        do_xfer(1'b0, 32'h10, '0, '0, rd, cyc, se);
        checks++; if (rd !== 32'h00220044) begin errors++; $display("FAIL strobe_read_data: got 0x%08h expected 0x00220044", rd); end
    endtask

    task automatic test_zero_strobe();
        logic [31:0] rd; int cyc; logic se;
        do_xfer(1'b1, 32'h04, 32'h55667788, 4'b1111, rd, cyc, se);
        model_write(32'h04, 32'h55667788, 4'b1111);
        do_xfer(1'b1, 32'h04, 32'hFFFFFFFF, 4'b0000, rd, cyc, se);
        checks++; if (cyc != 1 || se !== 1'b0) begin errors++; $display("FAIL zero_strobe_write: got cycles=%0d slverr=%b expected cycles=1 slverr=0", cyc, se); end
        do_xfer(1'b0, 32'h04, '0, '0, rd, cyc, se);
        checks++; if (rd !== 32'h55667788) begin errors++; $display("FAIL zero_strobe_read: got 0x%08h expected 0x55667788", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; int cyc; logic se;
        do_xfer(1'b1, 32'h3C, 32'hCAFEF00D, 4'b1111, rd, cyc, se);
        model_write(32'h3C, 32'hCAFEF00D, 4'b1111);
        do_xfer(1'b0, 32'h06, '0, '0, rd, cyc, se);
        checks++; if (cyc != 1 || se !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL misaligned_read: got cycles=%0d slverr=%b data=0x%08h expected cycles=1 slverr=1 data=0", cyc, se, rd);
        end
        do_xfer(1'b1, 32'h40, 32'h12345678, 4'b1111, rd, cyc, se);
        checks++; if (cyc != 1 || se !== 1'b1) begin errors++; $display("FAIL range_write: got cycles=%0d slverr=%b expected cycles=1 slverr=1", cyc, se); end
        do_xfer(1'b1, 32'hFFFFFFFC, 32'h9ABCDEF0, 4'b1111, rd, cyc, se);
        checks++; if (cyc != 1 || se !== 1'b1) begin errors++; $display("FAIL wrap_write: got cycles=%0d slverr=%b expected cycles=1 slverr=1", cyc, se); end
        do_xfer(1'b1, 32'h3E, 32'h0BADBEEF, 4'b1111, rd, cyc, se);
        checks++; if (cyc != 1 || se !== 1'b1) begin errors++; $display("FAIL misaligned_write: got cycles=%0d slverr=%b expected cycles=1 slverr=1", cyc, se); end
        do_xfer(1'b0, 32'h3C, '0, '0, rd, cyc, se);
        checks++; if (rd !== model_read(32'h3C) || se !== 1'b0) begin
            errors++; $display("FAIL error_no_write: got 0x%08h expected 0x%08h", rd, model_read(32'h3C));
        end
        do_xfer(1'b0, 32'h00, '0, '0, rd, cyc, se);
        checks++; if (rd !== model_read(32'h00)) begin errors++; $display("FAIL error_no_write_low: got 0x%08h expected 0x%08h", rd, model_read(32'h00)); end
    endtask

    task automatic test_protocol_abort();
        logic [31:0] rd; int cyc; logic se;
        p_sel = 1'b1; p_enable = 1'b0; p_write = 1'b1;
        p_addr = 32'h20; p_wdata = 32'h77777777; p_strb = 4'b1111;
        @(posedge p_clk); #1;
        p_sel = 1'b0;
        @(posedge p_clk); #1;
        do_xfer(1'b0, 32'h20, '0, '0, rd, cyc, se);
        checks++; if (rd !== model_read(32'h20) || cyc != 4) begin
            errors++; $display("FAIL abort_no_write: got data=0x%08h cycles=%0d expected data=0x%08h cycles=4", rd, cyc, model_read(32'h20));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, addr, wd, exp_rd; logic [3:0] st; logic wr, se; int cyc, ecyc, kind;
        for (int t = 0; t < 60; t++) begin
            wr   = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 99));
            if (kind < 70)      addr = 32'($urandom_range(0, DEPTH / DB - 1) * DB);
            else if (kind < 85) addr = 32'($urandom_range(0, DEPTH - 1)) | 32'h1;
            else                addr = $urandom() | 32'h40;
            wd = $urandom();
            st = 4'($urandom_range(0, 15));
            ecyc = exp_cycles(wr, addr, st);
            exp_rd = model_read(addr);
            do_xfer(wr, addr, wd, st, rd, cyc, se);
            if (wr) model_write(addr, wd, st);
            checks++; if (cyc != ecyc || se !== bad_addr(addr)) begin
                errors++; $display("FAIL rand%0d_timing: got cycles=%0d slverr=%b expected cycles=%0d slverr=%b", t, cyc, se, ecyc, bad_addr(addr));
            end
            if (!wr) begin
                checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand%0d_rdata: got 0x%08h expected 0x%08h", t, rd, exp_rd); end
            end
            if ($urandom_range(0, 2) == 0) begin
                @(posedge p_clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int cyc; logic se;
        do_xfer(1'b1, 32'h08, 32'h13572468, 4'b1111, rd, cyc, se);
        p_sel = 1'b1; p_enable = 1'b0; p_write = 1'b1;
        p_addr = 32'h00; p_wdata = 32'hDEADBEEF; p_strb = 4'b1111;
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        @(negedge p_clk);
        @(posedge p_clk); #1;
        @(negedge p_clk);
        p_resetn = 1'b0;
        #1;
        checks++; if (p_ready !== 1'b0 || p_slverr !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ready: got ready=%b slverr=%b expected 0 0", p_ready, p_slverr);
        end
        checks++; if (p_rdata !== 32'h0) begin errors++; $display("FAIL reset_mid_rdata: got 0x%08h expected 0", p_rdata); end
        @(posedge p_clk); #1;
        p_sel = 1'b0; p_enable = 1'b0;
        @(negedge p_clk);
        p_resetn = 1'b1;
        model_clear();
        @(posedge p_clk); #1;
        do_xfer(1'b0, 32'h00, '0, '0, rd, cyc, se);
        checks++; if (rd !== 32'h0 || cyc != 4) begin errors++; $display("FAIL reset_mid_read0: got data=0x%08h cycles=%0d expected data=0 cycles=4", rd, cyc); end
        do_xfer(1'b0, 32'h08, '0, '0, rd, cyc, se);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mid_read8: got 0x%08h expected 0", rd); end
    endtask

    initial begin
        #2;
        test_reset();
`ifdef APB_SLV_WAIT_CNT_EN
        test_wait_cnt();
`endif
        test_full_write_read();
        test_partial_strobe();
        test_zero_strobe();
        test_errors();
        test_protocol_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
